// File: rtl/ocp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ocp_pkg
//  Description : Shared OCP protocol encodings: master commands, slave
//                response codes and burst-sequence codes.
//  Revision    : 1.0  - initial release
// ============================================================================
package ocp_pkg;

    // MCmd encodings
    typedef enum logic [2:0] {
        CMD_IDLE = 3'd0,
        CMD_WR   = 3'd1,
        CMD_RD   = 3'd2,
        CMD_RDEX = 3'd3,
        CMD_RDL  = 3'd4,
        CMD_WRNP = 3'd5,
        CMD_WRC  = 3'd6,
        CMD_BCST = 3'd7
    } ocp_cmd_e;

    // SResp encodings (RESP_FL is the OCP "request failed" code)
    typedef enum logic [1:0] {
        RESP_NULL = 2'd0,
        RESP_DVA  = 2'd1,
        RESP_FL   = 2'd2,
        RESP_ERR  = 2'd3
    } ocp_resp_e;

    // MBurstSeq encodings
    typedef enum logic [2:0] {
        SEQ_INCR  = 3'd0,
        SEQ_DFLT1 = 3'd1,
        SEQ_WRAP  = 3'd2,
        SEQ_DFLT2 = 3'd3,
        SEQ_XOR   = 3'd4,
        SEQ_STRM  = 3'd5,
        SEQ_UNKN  = 3'd6,
        SEQ_BLCK  = 3'd7
    } ocp_seq_e;

endpackage : ocp_pkg
`default_nettype wire

// File: rtl/ocp_slave_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : ocp_slave_mem_array
//  Description : Word-addressed storage for ocp_slave_mem. One synchronous
//                write port with per-byte enables, one combinational read
//                port. Contents are never reset.
//  Ports       : clk      - write clock
//                i_we     - write enable
//                i_waddr  - write word address
//                i_wdata  - write data
//                i_wbe    - per-byte write enables
//                i_raddr  - read word address
//                o_rdata  - read data (combinational)
//  Revision    : 1.0  - initial release
// ============================================================================
module ocp_slave_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [ADDR_WIDTH-1:0]   i_waddr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wbe,
    input  logic [ADDR_WIDTH-1:0]   i_raddr,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;
    localparam int c_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (i_wbe[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : ocp_slave_mem_array
`default_nettype wire

// File: rtl/ocp_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : ocp_slave_mem
//  Description : OCP slave wrapping a small word memory. Supports INCR
//                bursts of WR (posted), WRNP (non-posted, single response)
//                and RD. Every other command or burst sequence is answered
//                with a single ERR beat and leaves memory untouched.
//  Ports       : clk, rst              - clock, async active-high reset
//                m_addr/m_burst_*      - request address and burst shape
//                m_cmd/m_tagid         - request command and tag
//                m_data*               - write data channel
//                m_resp_accept         - master response handshake
//                m_byteen, m_req_info,
//                m_data_tagid          - accepted but unused
//                s_cmd_accept          - request accepted (IDLE only)
//                s_data_accept         - write beat accepted (WDATA only)
//                s_resp/s_resp_last/
//                s_data/s_tagid        - response channel
//  Revision    : 1.0  - initial release
// ============================================================================
module ocp_slave_mem
    import ocp_pkg::*;
#(
    parameter int TAGI_WIDTH = 5,
    parameter int INFO_WIDTH = 4,
    parameter int BLEN_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   m_addr,
    input  logic [BLEN_WIDTH-1:0]   m_burst_length,
    input  logic [2:0]              m_burst_seq,
    input  logic [DATA_WIDTH/8-1:0] m_byteen,
    input  logic [2:0]              m_cmd,
    input  logic [DATA_WIDTH-1:0]   m_data,
    input  logic [DATA_WIDTH/8-1:0] m_data_byteen,
    input  logic                    m_data_last,
    input  logic [TAGI_WIDTH-1:0]   m_data_tagid,
    input  logic                    m_data_valid,
    input  logic [INFO_WIDTH-1:0]   m_req_info,
    input  logic                    m_resp_accept,
    input  logic [TAGI_WIDTH-1:0]   m_tagid,
    output logic                    s_cmd_accept,
    output logic [DATA_WIDTH-1:0]   s_data,
    output logic                    s_data_accept,
    output logic [1:0]              s_resp,
    output logic                    s_resp_last,
    output logic [TAGI_WIDTH-1:0]   s_tagid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_e                r_state;
    logic                  r_ready;      // low until the first edge after reset
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BLEN_WIDTH-1:0] r_last_beat;  // effective length minus one
    logic [BLEN_WIDTH-1:0] r_beat;
    logic [TAGI_WIDTH-1:0] r_tag;
    logic [2:0]            r_cmd;
    // In WDATA: sticky m_data_last mismatch. In RESP: response is ERR.
    logic                  r_err;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_e                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [BLEN_WIDTH-1:0] w_last_beat_nxt;
    logic [BLEN_WIDTH-1:0] w_beat_nxt;
    logic [TAGI_WIDTH-1:0] w_tag_nxt;
    logic [2:0]            w_cmd_nxt;
    logic                  w_err_nxt;

    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_beat_addr;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_is_last_beat;
    logic                  w_last_err;
    logic                  w_resp_last;
    logic                  w_rd_resp;

    // Beat address wraps naturally through the ADDR_WIDTH-bit sum.
    assign w_beat_addr    = r_addr + ADDR_WIDTH'(r_beat);
    assign w_is_last_beat = (r_beat == r_last_beat);
    assign w_last_err     = r_err | (m_data_last != w_is_last_beat);

    // Only a DVA read carries a multi-beat response; ERR and WRNP
    // responses are always a single beat.
    assign w_rd_resp   = (r_cmd == CMD_RD) && !r_err;
    assign w_resp_last = w_rd_resp ? w_is_last_beat : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_addr      <= '0;
            r_last_beat <= '0;
            r_beat      <= '0;
            r_tag       <= '0;
            r_cmd       <= CMD_IDLE;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ready     <= 1'b1;
            r_addr      <= w_addr_nxt;
            r_last_beat <= w_last_beat_nxt;
            r_beat      <= w_beat_nxt;
            r_tag       <= w_tag_nxt;
            r_cmd       <= w_cmd_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_last_beat_nxt = r_last_beat;
        w_beat_nxt      = r_beat;
        w_tag_nxt       = r_tag;
        w_cmd_nxt       = r_cmd;
        w_err_nxt       = r_err;
        w_mem_we        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_ready && (m_cmd != CMD_IDLE)) begin
                    w_addr_nxt      = m_addr;
                    w_last_beat_nxt = (m_burst_length == '0) ? '0
                                    : m_burst_length - BLEN_WIDTH'(1);
                    w_beat_nxt      = '0;
                    w_tag_nxt       = m_tagid;
                    w_cmd_nxt       = m_cmd;
                    w_err_nxt       = 1'b0;
                    if (((m_cmd == CMD_WR) || (m_cmd == CMD_WRNP)) &&
                        (m_burst_seq == SEQ_INCR)) begin
                        w_state_nxt = ST_WDATA;
                    end else if ((m_cmd == CMD_RD) && (m_burst_seq == SEQ_INCR)) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_err_nxt   = 1'b1;
                    end
                end
            end

            ST_WDATA: begin
                if (m_data_valid) begin
                    w_mem_we = 1'b1;
                    if (w_is_last_beat) begin
                        w_beat_nxt = '0;
                        if (r_cmd == CMD_WRNP) begin
                            w_state_nxt = ST_RESP;
                            w_err_nxt   = w_last_err;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_err_nxt   = 1'b0;
                        end
                    end else begin
                        w_beat_nxt = r_beat + BLEN_WIDTH'(1);
                        w_err_nxt  = w_last_err;
                    end
                end
            end

            ST_RESP: begin
                if (m_resp_accept) begin
                    if (w_resp_last) begin
                        w_state_nxt = ST_IDLE;
                        w_beat_nxt  = '0;
                    end else begin
                        w_beat_nxt  = r_beat + BLEN_WIDTH'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: pure decodes of registered state
    // ------------------------------------------------------------------
    assign s_cmd_accept  = r_ready && (r_state == ST_IDLE);
    assign s_data_accept = (r_state == ST_WDATA);
    assign s_resp        = (r_state != ST_RESP) ? RESP_NULL
                         : (r_err ? RESP_ERR : RESP_DVA);
    assign s_resp_last   = (r_state == ST_RESP) && w_resp_last;
    assign s_data        = ((r_state == ST_RESP) && w_rd_resp) ? w_rd_data : '0;
    assign s_tagid       = r_tag;

    ocp_slave_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_beat_addr),
        .i_wdata (m_data),
        .i_wbe   (m_data_byteen),
        .i_raddr (w_beat_addr),
        .o_rdata (w_rd_data)
    );

    // Request byte enables, request info and write-data tags carry no
    // meaning for this slave.
    logic w_unused_inputs;
    assign w_unused_inputs = ^{m_byteen, m_req_info, m_data_tagid};

endmodule : ocp_slave_mem
`default_nettype wire

// File: tb/tb_ocp_slave_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ocp_slave_mem
//  Description : Self-checking bench for ocp_slave_mem. A word-array model
//                of memory produces expected responses at command issue
//                time; a monitor pops and compares on every accepted
//                response beat and checks that stalled beats hold still.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_ocp_slave_mem;
    import ocp_pkg::*;

    localparam int c_DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  m_addr = '0;
    logic [3:0]  m_burst_length = '0;
    logic [2:0]  m_burst_seq = '0;
    logic [3:0]  m_byteen = '0;
    logic [2:0]  m_cmd = CMD_IDLE;
    logic [31:0] m_data = '0;
    logic [3:0]  m_data_byteen = '0;
    logic        m_data_last = 1'b0;
    logic [4:0]  m_data_tagid = '0;
    logic        m_data_valid = 1'b0;
    logic [3:0]  m_req_info = '0;
    logic        m_resp_accept;
    logic [4:0]  m_tagid = '0;
    logic        s_cmd_accept;
    logic [31:0] s_data;
    logic        s_data_accept;
    logic [1:0]  s_resp;
    logic        s_resp_last;
    logic [4:0]  s_tagid;

    ocp_slave_mem #(
        .TAGI_WIDTH (5), .INFO_WIDTH (4), .BLEN_WIDTH (4),
        .DATA_WIDTH (32), .ADDR_WIDTH (5)
    ) dut (
        .clk (clk), .rst (rst),
        .m_addr (m_addr), .m_burst_length (m_burst_length),
        .m_burst_seq (m_burst_seq), .m_byteen (m_byteen), .m_cmd (m_cmd),
        .m_data (m_data), .m_data_byteen (m_data_byteen),
        .m_data_last (m_data_last), .m_data_tagid (m_data_tagid),
        .m_data_valid (m_data_valid), .m_req_info (m_req_info),
        .m_resp_accept (m_resp_accept), .m_tagid (m_tagid),
        .s_cmd_accept (s_cmd_accept), .s_data (s_data),
        .s_data_accept (s_data_accept), .s_resp (s_resp),
        .s_resp_last (s_resp_last), .s_tagid (s_tagid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic        last;
        logic [4:0]  tag;
        bit          chk_data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [c_DEPTH];
    logic [31:0] wd [16];
    logic [3:0]  wb [16];
    int          stall_req = 0;
    int          stall_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: compares each accepted beat against the scoreboard
    // and checks that a stalled beat does not change.
    initial begin : monitor
        bit          prev_stall;
        logic [31:0] h_data;
        logic [7:0]  h_ctl;
        exp_t        e;
        prev_stall = 0;
        forever begin
            @(negedge clk);
            if (!rst && s_resp != RESP_NULL) begin
                if (prev_stall) begin
                    chk("hold_data", s_data, h_data);
                    chk("hold_ctl", {24'd0, s_resp, s_resp_last, s_tagid}, {24'd0, h_ctl});
                end
                if (m_resp_accept) begin
                    prev_stall = 0;
                    if (sb.size() == 0) begin
                        chk("unexpected_resp", 32'(s_resp), 32'(RESP_NULL));
                    end else begin
                        e = sb.pop_front();
                        chk("resp_code", 32'(s_resp), 32'(e.resp));
                        chk("resp_last", 32'(s_resp_last), 32'(e.last));
                        chk("resp_tag", 32'(s_tagid), 32'(e.tag));
                        if (e.chk_data) chk("resp_data", s_data, e.data);
                    end
                end else begin
                    prev_stall = 1;
                    h_data     = s_data;
                    h_ctl      = {s_resp, s_resp_last, s_tagid};
                    stall_seen++;
                end
            end else begin
                prev_stall = 0;
            end
        end
    end

    // Response acceptance: mostly accepting, with a forced 5-cycle stall on
    // the first beat seen after stall_req is raised.
    initial begin : accept_drv
        int stall_cnt;
        stall_cnt     = 0;
        m_resp_accept = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stall_req != 0 && s_resp != RESP_NULL) begin
                stall_cnt = 5;
                stall_req = 0;
            end
            if (stall_cnt > 0) begin
                m_resp_accept = 1'b0;
                stall_cnt--;
            end else begin
                m_resp_accept = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    task automatic fill_data(input bit rand_be);
        for (int i = 0; i < 16; i++) begin
            wd[i] = $urandom;
            wb[i] = rand_be ? 4'($urandom_range(0, 15)) : 4'hF;
        end
    endtask

    // Issue one transaction. bad_last >= 0 raises m_data_last on that beat
    // only (must be before the final beat). abort_after >= 0 stops the data
    // phase after that many beats. Called at posedge+1.
    task automatic run_txn(input logic [2:0] cmd, input logic [2:0] seq, input int addr,
                           input int blen, input logic [4:0] tag,
                           input int bad_last, input int abort_after);
        int   len;
        bit   is_wr, is_rd, ok;
        exp_t e;
        len   = (blen == 0) ? 1 : blen;
        is_wr = (cmd == CMD_WR || cmd == CMD_WRNP) && seq == SEQ_INCR;
        is_rd = (cmd == CMD_RD) && seq == SEQ_INCR;
        if (is_rd) begin
            for (int k = 0; k < len; k++) begin
                e = '{RESP_DVA, model_mem[(addr + k) % c_DEPTH], (k == len - 1), tag, 1'b1};
                sb.push_back(e);
            end
        end else if (!is_wr) begin
            e = '{RESP_ERR, 32'd0, 1'b1, tag, 1'b1};
            sb.push_back(e);
        end else if (cmd == CMD_WRNP) begin
            e = '{(bad_last >= 0) ? RESP_ERR : RESP_DVA, 32'd0, 1'b1, tag, 1'b0};
            sb.push_back(e);
        end

        m_cmd = cmd; m_addr = 5'(addr); m_burst_length = 4'(blen);
        m_burst_seq = seq; m_tagid = tag;
        m_byteen = 4'($urandom); m_req_info = 4'($urandom);
        // Data valid alongside the command must be ignored.
        m_data_valid = 1'($urandom); m_data = $urandom; m_data_byteen = 4'hF;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); ok = s_cmd_accept;
            @(posedge clk); #1;
        end
        m_cmd = CMD_IDLE; m_data_valid = 1'b0;
        if (!ok) begin
            chk("cmd_accept_timeout", 32'd0, 32'd1);
            return;
        end
        if (!is_wr) return;

        for (int b = 0; b < len; b++) begin
            if (abort_after >= 0 && b == abort_after) return;
            if ($urandom_range(0, 3) == 0) begin
                m_data_valid = 1'b0;
                @(posedge clk); #1;
            end
            m_data_valid  = 1'b1;
            m_data        = wd[b];
            m_data_byteen = wb[b];
            m_data_tagid  = 5'($urandom);
            if (cmd == CMD_WR)     m_data_last = 1'($urandom);
            else if (bad_last >= 0) m_data_last = (b == bad_last);
            else                   m_data_last = (b == len - 1);
            @(negedge clk);
            chk("data_accept", 32'(s_data_accept), 32'd1);
            @(posedge clk); #1;
            model_mem[(addr + b) % c_DEPTH] = merge(model_mem[(addr + b) % c_DEPTH], wd[b], wb[b]);
        end
        m_data_valid = 1'b0;
        m_data_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin : stim
        logic [2:0] c;
        int         kind;
        logic [2:0] err_cmds [4];
        err_cmds[0] = CMD_RDEX; err_cmds[1] = CMD_RDL;
        err_cmds[2] = CMD_WRC;  err_cmds[3] = CMD_BCST;
        for (int i = 0; i < c_DEPTH; i++) model_mem[i] = '0;

        // Reset state
        #12;
        chk("rst_cmd_accept", 32'(s_cmd_accept), 32'd0);
        chk("rst_data_accept", 32'(s_data_accept), 32'd0);
        chk("rst_resp", {30'd0, s_resp}, 32'd0);
        chk("rst_resp_last", 32'(s_resp_last), 32'd0);
        chk("rst_data", s_data, 32'd0);
        chk("rst_tagid", 32'(s_tagid), 32'd0);
        @(negedge clk); rst = 1'b0;
        #1 chk("accept_before_first_edge", 32'(s_cmd_accept), 32'd0);
        @(posedge clk); #1;
        chk("accept_after_first_edge", 32'(s_cmd_accept), 32'd1);

        // Known contents everywhere
        for (int a = 0; a < c_DEPTH; a += 8) begin
            fill_data(0);
            run_txn(CMD_WR, SEQ_INCR, a, 8, 5'd1, -1, -1);
        end

        // Posted burst then read-back with tag echo
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; wb[i] = 4'hF; end
        run_txn(CMD_WR, SEQ_INCR, 3, 4, 5'd2, -1, -1);
        run_txn(CMD_RD, SEQ_INCR, 3, 4, 5'd19, -1, -1);

        // Non-posted write wrapping past the top address
        wd[0] = 32'h11; wd[1] = 32'h22; wb[0] = 4'hF; wb[1] = 4'hF;
        run_txn(CMD_WRNP, SEQ_INCR, 31, 2, 5'd7, -1, -1);
        run_txn(CMD_RD, SEQ_INCR, 31, 2, 5'd8, -1, -1);

        // Partial byte enables
        wd[0] = 32'hFFFF_FFFF; wb[0] = 4'hF;
        run_txn(CMD_WR, SEQ_INCR, 7, 1, 5'd3, -1, -1);
        wd[0] = 32'h1234_5678; wb[0] = 4'h5;
        run_txn(CMD_WR, SEQ_INCR, 7, 1, 5'd4, -1, -1);
        run_txn(CMD_RD, SEQ_INCR, 7, 1, 5'd5, -1, -1);

        // Held first beat of a 3-beat read
        wait_drain();
        stall_req = 1;
        run_txn(CMD_RD, SEQ_INCR, 10, 3, 5'd9, -1, -1);
        wait_drain();

        // Error responses and the m_data_last mismatch case
        run_txn(CMD_BCST, SEQ_INCR, 4, 2, 5'd10, -1, -1);
        run_txn(CMD_RD, SEQ_WRAP, 4, 4, 5'd11, -1, -1);
        fill_data(0);
        run_txn(CMD_WRNP, SEQ_INCR, 20, 3, 5'd12, 0, -1);
        run_txn(CMD_RD, SEQ_INCR, 4, 0, 5'd13, -1, -1);
        run_txn(CMD_RD, SEQ_INCR, 20, 3, 5'd14, -1, -1);

        // Reset in the middle of a posted burst
        wait_drain();
        fill_data(0);
        run_txn(CMD_WR, SEQ_INCR, 12, 4, 5'd15, -1, 2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_data_accept", 32'(s_data_accept), 32'd0);
        chk("midrst_cmd_accept", 32'(s_cmd_accept), 32'd0);
        chk("midrst_resp", {30'd0, s_resp}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_accept_after", 32'(s_cmd_accept), 32'd1);
        run_txn(CMD_RD, SEQ_INCR, 12, 4, 5'd16, -1, -1);

        // Randomized traffic
        for (int t = 0; t < 50; t++) begin
            kind = $urandom_range(0, 9);
            fill_data(1);
            if (kind <= 2)
                run_txn(CMD_WR, SEQ_INCR, $urandom_range(0, 31), $urandom_range(0, 15),
                        5'($urandom), -1, -1);
            else if (kind <= 4)
                run_txn(CMD_WRNP, SEQ_INCR, $urandom_range(0, 31), 2 + $urandom_range(0, 13),
                        5'($urandom), ($urandom_range(0, 2) == 0) ? 0 : -1, -1);
            else if (kind <= 7)
                run_txn(CMD_RD, SEQ_INCR, $urandom_range(0, 31), $urandom_range(0, 15),
                        5'($urandom), -1, -1);
            else if (kind == 8)
                run_txn(err_cmds[$urandom_range(0, 3)], SEQ_INCR, $urandom_range(0, 31),
                        $urandom_range(0, 15), 5'($urandom), -1, -1);
            else begin
                c = ($urandom_range(0, 1) == 0) ? CMD_RD : CMD_WR;
                run_txn(c, 3'($urandom_range(1, 7)), $urandom_range(0, 31),
                        $urandom_range(0, 15), 5'($urandom), -1, -1);
            end
        end

        wait_drain();
        chk("stall_cycles_seen", 32'(stall_seen >= 5), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ocp_slave_mem
`default_nettype wire

// File: doc/ocp_slave_mem.md
OCP_SLAVE_MEM -- requirements
Module: ocp_slave_mem

Interface
REQ-001 Parameter TAGI_WIDTH, default 5, tag-ID width.
REQ-002 Parameter INFO_WIDTH, default 4, m_req_info width.
REQ-003 Parameter BLEN_WIDTH, default 4, burst-length width.
REQ-004 Parameter DATA_WIDTH, default 32, data word width (multiple of 8).
REQ-005 Parameter ADDR_WIDTH, default 5, word address width; memory depth 2**ADDR_WIDTH words.
REQ-006 Ports SHALL be, in order:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- m_addr  input  ADDR_WIDTH  word address.
- m_burst_length  input  BLEN_WIDTH  beats.
- m_burst_seq  input  3  burst sequence.
- m_byteen  input  DATA_WIDTH/8  request byte enables (ignored).
- m_cmd  input  3  command.
- m_data  input  DATA_WIDTH  write data.
- m_data_byteen  input  DATA_WIDTH/8  write byte enables.
- m_data_last  input  1  last write beat.
- m_data_tagid  input  TAGI_WIDTH  write-data tag (ignored).
- m_data_valid  input  1  write data valid.
- m_req_info  input  INFO_WIDTH  request info (ignored).
- m_resp_accept  input  1  master accepts response.
- m_tagid  input  TAGI_WIDTH  request tag.
- s_cmd_accept  output  1  command accepted.
- s_data  output  DATA_WIDTH  read data.
- s_data_accept  output  1  write beat accepted.
- s_resp  output  2  response code.
- s_resp_last  output  1  last response beat.
- s_tagid  output  TAGI_WIDTH  response tag.

Function
REQ-007 FSM states: IDLE, WDATA, RESP; all outputs registered or decoded from registered state.
REQ-008 s_cmd_accept=1 only in IDLE; command transfer = IDLE and m_cmd!=IDLE; registers addr, length, tag, cmd.
REQ-009 Effective length L = m_burst_length, 0 means 1; beat address = (addr + beat) mod 2**ADDR_WIDTH.
REQ-010 WR or WRNP with m_burst_seq=INCR -> WDATA; s_data_accept=1 in WDATA; each cycle with m_data_valid writes one beat, per-byte gated by m_data_byteen.
REQ-011 WDATA exits after beat L: WR (posted) -> IDLE, no response; WRNP -> RESP, one beat, s_resp_last=1.
REQ-012 WRNP response SHALL be DVA, or ERR if m_data_last mismatched beat L on any beat; WR ignores m_data_last. Data always written.
REQ-013 RD with INCR -> RESP next cycle; beat k: s_resp=DVA, s_data=mem[addr+k], s_tagid=tag, s_resp_last=(k==L-1).
REQ-014 Response beat held stable until m_resp_accept=1; after last accepted beat -> IDLE; first RD beat one cycle after command accept.
REQ-015 RDEX, RDL, WRC, BCST, or any non-INCR burst_seq -> RESP, single ERR beat, s_data=0, s_resp_last=1, no data phase, memory unchanged.
REQ-016 Outside RESP: s_resp=NULL, s_resp_last=0, s_data=0; m_data_valid outside WDATA ignored.
REQ-017 Back-to-back: after returning to IDLE, next command accepted no earlier than the following cycle.

Reset
REQ-018 rst asserted -> state IDLE, beat counter 0, s_cmd_accept=0, s_data_accept=0, s_resp=NULL, s_resp_last=0, s_data=0, s_tagid=0, asynchronously.
REQ-019 Reset mid-burst aborts the transaction with no response; written beats kept; memory contents never reset.
REQ-020 s_cmd_accept=1 from the first clk edge after rst deasserts.

Structure
REQ-021 Command, response and burst-sequence codes SHALL come from ocp_pkg; FSM state enum local to the module.
REQ-022 Storage SHALL be sub-module ocp_slave_mem_array: one write port with byte enables, one combinational read port.

Verification
REQ-023 WR addr 3, len 4, data 0xA0..0xA3, byteen 0xF -> no response; RD addr 3, len 4 -> DVA 0xA0..0xA3, s_resp_last on 4th beat, tag echoed.
REQ-024 WRNP addr 31, len 2, data 0x11,0x22 -> mem[31]=0x11, mem[0]=0x22 (wrap), single DVA beat.
REQ-025 WR 0xFFFFFFFF then WR 0x12345678 byteen 0x5 to addr 7 -> RD returns 0xFF34FF78.
REQ-026 RD len 3 with m_resp_accept low 5 cycles on beat 1 -> s_data, s_resp held stable; 3 beats total.
REQ-027 m_cmd=BCST, or RD with burst_seq=WRAP -> single ERR beat, s_data=0; WRNP with m_data_last on beat 1 of 3 -> ERR.
REQ-028 rst asserted during beat 2 of WR len 4 -> no response, s_cmd_accept=1 after release, beats 1-2 present.
